// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared state encoding and default width for the exponentiation sequencer
package rsa_pkg;

  localparam int DEFAULT_MOD_WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    MUL_REQ,
    MUL_WAIT,
    SQR_REQ,
    SQR_WAIT,
    DONE
  } ExpState_t;

endpackage

// File: rtl/rsa_mul_port.sv
// rtl/rsa_mul_port.sv - request/response shell toward the external Montgomery multiplier
module rsa_mul_port
  import rsa_pkg::*;
#(
  parameter int W = DEFAULT_MOD_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         wait_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_a_o,
  output logic [W-1:0] m_b_o,
  input  logic         r_valid_i,
  output logic         r_ready_o,
  output logic         req_done_o,
  output logic         rsp_done_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;

  assign req_done_o = valid_q && m_ready_i;
  assign rsp_done_o = r_valid_i && wait_i;
  assign r_ready_o  = wait_i;
  assign m_valid_o  = valid_q;
  assign m_a_o      = a_q;
  assign m_b_o      = b_q;

  // Operands are captured once on entry to a request and frozen until accepted.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    if (load_i) begin
      valid_d = 1'b1;
      a_d     = a_i;
      b_d     = b_i;
    end else if (req_done_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: rtl/rsa_mont_exp.sv
// rtl/rsa_mont_exp.sv - right-to-left modular exponentiation sequencer around an external Montgomery multiplier
// Optional early termination once the remaining exponent bits are zero: RSA_EXP_EARLY_EXIT_EN.
module rsa_mont_exp
  import rsa_pkg::*;
#(
  parameter int MOD_WIDTH = DEFAULT_MOD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_base_mont,
  input  logic [MOD_WIDTH-1:0] i_exp,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_modulus,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [MOD_WIDTH-1:0] r_out
);

  localparam int CW = $clog2(MOD_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(MOD_WIDTH - 1);
  localparam logic [MOD_WIDTH-1:0] ONE = MOD_WIDTH'(1);
`ifdef RSA_EXP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  ExpState_t              state_q, state_d;
  logic [MOD_WIDTH-1:0]   acc_q, acc_d, sq_q, sq_d, exp_q, exp_d, mod_q, mod_d, out_q, out_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   load, in_wait, req_done, rsp_done;
  logic [MOD_WIDTH-1:0]   port_a;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: if (i_valid) begin
        acc_d = ONE;
        sq_d  = i_base_mont;
        exp_d = i_exp;
        mod_d = i_modulus;
        cnt_d = '0;
        if (i_exp[0]) begin
          state_d = MUL_REQ;
        end else if (EARLY && i_exp == '0) begin
          state_d = DONE;
          out_d   = ONE;
        end else begin
          state_d = SQR_REQ;
        end
      end
      MUL_REQ: if (req_done) state_d = MUL_WAIT;
      MUL_WAIT: if (rsp_done) begin
        acc_d = r_out;
        if (cnt_q == LAST_BIT || (EARLY && (exp_q >> 1) == '0)) begin
          state_d = DONE;
          out_d   = r_out;
        end else begin
          state_d = SQR_REQ;
        end
      end
      SQR_REQ: if (req_done) state_d = SQR_WAIT;
      SQR_WAIT: if (rsp_done) begin
        sq_d  = r_out;
        exp_d = exp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // exp_q[1] is the bit that becomes current after this shift.
        if (exp_q[1]) begin
          state_d = MUL_REQ;
        end else if (cnt_d == LAST_BIT || (EARLY && (exp_q >> 2) == '0)) begin
          state_d = DONE;
          out_d   = acc_q;
        end else begin
          state_d = SQR_REQ;
        end
      end
      DONE: if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load    = (state_d == MUL_REQ || state_d == SQR_REQ) &&
                   !(state_q == MUL_REQ || state_q == SQR_REQ);
  assign port_a  = (state_d == MUL_REQ) ? acc_d : sq_d;
  assign in_wait = (state_q == MUL_WAIT) || (state_q == SQR_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sq_q    <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  rsa_mul_port #(.W(MOD_WIDTH)) u_port (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .a_i        (port_a),
    .b_i        (sq_d),
    .wait_i     (in_wait),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_a_o      (m_a),
    .m_b_o      (m_b),
    .r_valid_i  (r_valid),
    .r_ready_o  (r_ready),
    .req_done_o (req_done),
    .rsp_done_o (rsp_done)
  );

  assign i_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_out     = out_q;
  assign m_modulus = mod_q;

endmodule

// File: tb/tb_rsa_mont_exp.sv
// tb/tb_rsa_mont_exp.sv - directed bench for rsa_mont_exp with a behavioural Montgomery multiplier (N=13, width 8)
module tb_rsa_mont_exp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0, i_ready;
  logic [7:0] i_base_mont = '0, i_exp = '0, i_modulus = '0;
  logic       o_valid, o_ready = 1'b0;
  logic [7:0] o_out;
  logic       m_valid, m_ready;
  logic [7:0] m_a, m_b, m_modulus;
  logic       r_valid, r_ready;
  logic [7:0] r_out;

  int n_pass = 0, n_total = 0;
  int mul_cnt = 0, first_mul = -1, stall_cfg = 0, lat_cfg = 0;
  int unstable = 0, mod_err = 0, proto_err = 0;
  logic [7:0] hold_a, hold_b;

`ifdef RSA_EXP_EARLY_EXIT_EN
  localparam int EXP5_MULS = 4;
  localparam int EXP0_MULS = 0;
  localparam int EXP0_LAT  = 1;
`else
  localparam int EXP5_MULS = 9;
  localparam int EXP0_MULS = 7;
  localparam int EXP0_LAT  = 15;
`endif

  always #5 clk = ~clk;

  rsa_mont_exp #(.MOD_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_base_mont(i_base_mont), .i_exp(i_exp), .i_modulus(i_modulus),
    .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_a(m_a), .m_b(m_b), .m_modulus(m_modulus),
    .r_valid(r_valid), .r_ready(r_ready), .r_out(r_out)
  );

  // a*b*R^-1 mod n with R = 256
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    int rinv;
    rinv = 0;
    if (n == 0) return 8'd0;
    for (int x = 1; x < int'(n); x++) if (((256 * x) % int'(n)) == 1) rinv = x;
    return 8'((int'(a) * int'(b) * rinv) % int'(n));
  endfunction

  // Multiplier model: decides m_ready / r_valid at each falling edge for the next rising edge.
  initial begin
    automatic bit m_fire = 0, r_fire = 0, have = 0;
    automatic int stall_n = 0, wait_n = 0;
    automatic logic [7:0] prod = '0;
    m_ready = 1'b0;
    r_valid = 1'b0;
    r_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_fire = 0; r_fire = 0; have = 0; stall_n = 0;
        m_ready = 1'b0; r_valid = 1'b0;
      end else begin
        if (m_fire) begin
          if (m_valid) proto_err++;
          have = 1; wait_n = lat_cfg; stall_n = 0;
        end
        if (r_fire) r_valid = 1'b0;
        if (have) begin
          if (wait_n > 0) wait_n--;
          else begin r_valid = 1'b1; r_out = prod; have = 0; end
        end
        m_ready = 1'b0;
        if (m_valid) begin
          if (m_modulus !== 8'd13) mod_err++;
          if (have || r_valid) proto_err++;
          else if (stall_n < stall_cfg) begin
            if (stall_n == 0) begin hold_a = m_a; hold_b = m_b; end
            else if (m_a !== hold_a || m_b !== hold_b) unstable++;
            stall_n++;
          end else begin
            if (stall_cfg > 0 && (m_a !== hold_a || m_b !== hold_b)) unstable++;
            m_ready = 1'b1;
            prod = mont(m_a, m_b, m_modulus);
            if (m_a !== m_b && first_mul < 0) first_mul = mul_cnt;
            mul_cnt++;
          end
        end
        m_fire = m_valid && m_ready;
        r_fire = r_valid && r_ready;
      end
    end
  end

  task automatic run_job(input logic [7:0] base, input logic [7:0] e, input int ostall,
                         output logic [7:0] res, output int lat, output int mcount,
                         output int hold_err, output logic idle_after);
    int start;
    start = mul_cnt; hold_err = 0; lat = 0; res = 'x; idle_after = 1'b0;
    @(negedge clk);
    i_base_mont = base; i_exp = e; i_modulus = 8'd13; i_valid = 1'b1;
    @(negedge clk);
    // Keep requesting with junk operands while busy; the block must ignore them.
    i_base_mont = 8'hAA; i_exp = 8'hFF; i_modulus = 8'h0F;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 3000) begin @(negedge clk); lat++; end
    i_valid = 1'b0;
    if (o_valid === 1'b1) begin
      res = o_out;
      for (int k = 0; k < ostall; k++) begin
        @(negedge clk);
        if (o_valid !== 1'b1 || o_out !== res) hold_err++;
      end
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      idle_after = (i_ready === 1'b1) && (o_valid === 1'b0);
    end
    mcount = mul_cnt - start;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_total++; if (i_ready !== 1'b1) $display("FAIL reset_i_ready got=%b want=1", i_ready); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid got=%b want=0", o_valid); else n_pass++;
    n_total++; if (o_out !== 8'd0) $display("FAIL reset_o_out got=%0d want=0", o_out); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b want=0", m_valid); else n_pass++;
    n_total++; if (m_a !== 8'd0) $display("FAIL reset_m_a got=%0d want=0", m_a); else n_pass++;
    n_total++; if (m_b !== 8'd0) $display("FAIL reset_m_b got=%0d want=0", m_b); else n_pass++;
    n_total++; if (m_modulus !== 8'd0) $display("FAIL reset_m_modulus got=%0d want=0", m_modulus); else n_pass++;
    n_total++; if (r_ready !== 1'b0) $display("FAIL reset_r_ready got=%b want=0", r_ready); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_exp5;
    logic [7:0] res; int lat, mc, he; logic ia;
    run_job(8'd5, 8'd5, 0, res, lat, mc, he, ia);
    n_total++; if (res !== 8'd6) $display("FAIL exp5_result got=%0d want=6", res); else n_pass++;
    n_total++; if (mc !== EXP5_MULS) $display("FAIL exp5_mul_count got=%0d want=%0d", mc, EXP5_MULS); else n_pass++;
    n_total++; if (mod_err !== 0) $display("FAIL exp5_modulus_errors got=%0d want=0", mod_err); else n_pass++;
  endtask

  task automatic test_exp0;
    logic [7:0] res; int lat, mc, he; logic ia;
    run_job(8'd5, 8'd0, 0, res, lat, mc, he, ia);
    n_total++; if (res !== 8'd1) $display("FAIL exp0_result got=%0d want=1", res); else n_pass++;
    n_total++; if (mc !== EXP0_MULS) $display("FAIL exp0_mul_count got=%0d want=%0d", mc, EXP0_MULS); else n_pass++;
    n_total++; if (lat !== EXP0_LAT) $display("FAIL exp0_latency got=%0d want=%0d", lat, EXP0_LAT); else n_pass++;
  endtask

  task automatic test_exp_ff;
    logic [7:0] res; int lat, mc, he; logic ia;
    run_job(8'd1, 8'hFF, 0, res, lat, mc, he, ia);
    n_total++; if (res !== 8'd1) $display("FAIL expff_result got=%0d want=1", res); else n_pass++;
    n_total++; if (mc !== 15) $display("FAIL expff_mul_count got=%0d want=15", mc); else n_pass++;
  endtask

  task automatic test_exp80;
    logic [7:0] res; int lat, mc, he, start; logic ia;
    start = mul_cnt; first_mul = -1;
    run_job(8'd5, 8'h80, 0, res, lat, mc, he, ia);
    n_total++; if (res !== 8'd9) $display("FAIL exp80_result got=%0d want=9", res); else n_pass++;
    n_total++; if (first_mul - start !== 7) $display("FAIL exp80_first_mul_index got=%0d want=7", first_mul - start); else n_pass++;
    n_total++; if (mc !== 8) $display("FAIL exp80_mul_count got=%0d want=8", mc); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [7:0] res; int lat, mc, he; logic ia;
    stall_cfg = 3; unstable = 0;
    run_job(8'd5, 8'd5, 5, res, lat, mc, he, ia);
    stall_cfg = 0;
    n_total++; if (res !== 8'd6) $display("FAIL bp_result got=%0d want=6", res); else n_pass++;
    n_total++; if (unstable !== 0) $display("FAIL bp_operand_changes got=%0d want=0", unstable); else n_pass++;
    n_total++; if (he !== 0) $display("FAIL bp_o_out_changes got=%0d want=0", he); else n_pass++;
    n_total++; if (ia !== 1'b1) $display("FAIL bp_idle_after_handshake got=%b want=1", ia); else n_pass++;
    n_total++; if (mc !== EXP5_MULS) $display("FAIL bp_mul_count got=%0d want=%0d", mc, EXP5_MULS); else n_pass++;
  endtask

  task automatic test_reset_midjob;
    logic [7:0] res; int lat, mc, he, n; logic ia, reached;
    lat_cfg = 6;
    @(negedge clk);
    i_base_mont = 8'd5; i_exp = 8'd5; i_modulus = 8'd13; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!(r_ready === 1'b1 && m_a === m_b) && n < 200) begin @(negedge clk); n++; end
    reached = (r_ready === 1'b1) && (m_a === m_b);
    n_total++; if (reached !== 1'b1) $display("FAIL rst_reached_sqr_wait got=%b want=1", reached); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (i_ready !== 1'b1) $display("FAIL rst_i_ready got=%b want=1", i_ready); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got=%b want=0", m_valid); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL rst_o_valid got=%b want=0", o_valid); else n_pass++;
    n_total++; if (r_ready !== 1'b0) $display("FAIL rst_r_ready got=%b want=0", r_ready); else n_pass++;
    rst = 1'b0;
    lat_cfg = 0;
    run_job(8'd5, 8'd5, 0, res, lat, mc, he, ia);
    n_total++; if (res !== 8'd6) $display("FAIL rst_fresh_job_result got=%0d want=6", res); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_exp5();
    test_exp0();
    test_exp_ff();
    test_exp80();
    test_backpressure();
    test_reset_midjob();
    n_total++; if (proto_err !== 0) $display("FAIL protocol_violations got=%0d want=0", proto_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/rsa_mont_exp.md
# rsa_mont_exp

Modular-exponentiation sequencer that computes `base^exp mod N` by driving an external Montgomery multiplier through a request/response handshake. It sits directly upstream of the Montgomery multiplier: it feeds operand pairs in and consumes each product before issuing the next. Its own input comes from the pre-processing stage, which supplies the base already converted to Montgomery form. The result leaves in the plain (non-Montgomery) domain, so no final conversion is needed.

## Interface
- `MOD_WIDTH`, 256, operand, exponent and modulus width in bits
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `i_valid`  in  1  job request
- `i_ready`  out  1  block can accept a job; high only in IDLE
- `i_base_mont`  in  MOD_WIDTH  `base·2^MOD_WIDTH mod N`; must be < `i_modulus`
- `i_exp`  in  MOD_WIDTH  exponent
- `i_modulus`  in  MOD_WIDTH  N; must be odd and > 1
- `o_valid`  out  1  result valid
- `o_ready`  in  1  result consumed
- `o_out`  out  MOD_WIDTH  `base^exp mod N`
- `m_valid`  out  1  multiply request to the multiplier
- `m_ready`  in  1  multiplier accepts the request
- `m_a`, `m_b`, `m_modulus`  out  MOD_WIDTH each  multiplier operands
- `r_valid`  in  1  multiplier product valid
- `r_ready`  out  1  block accepts the product
- `r_out`  in  MOD_WIDTH  product `a·b·2^-MOD_WIDTH mod N`; treated as fully reduced

## Operation
- Registers:
  - `acc`: result in the plain domain; initialised to 1.
  - `sq`: running square in Montgomery form; initialised to `i_base_mont`.
  - `exp_sh`: exponent shift register; initialised to `i_exp`.
  - `mod_r`: modulus; initialised to `i_modulus`.
  - `bit_cnt`: 0..MOD_WIDTH-1.
- Job accept: `i_valid && i_ready` latches all inputs.
- Right-to-left binary method. For each bit, with `b = exp_sh[0]`:
  - If `b` = 1: `acc = Mont(acc, sq)`, which keeps `acc` in the plain domain.
  - If `bit_cnt != MOD_WIDTH-1`: `sq = Mont(sq, sq)`, then shift `exp_sh` right by 1 and increment `bit_cnt`.
  - The last bit never squares.
- States:
  - IDLE: on accept → MUL_REQ if `i_exp[0]`, else SQR_REQ (or DONE, see below).
  - MUL_REQ: drive `m_a=acc`, `m_b=sq`; on `m_ready` → MUL_WAIT.
  - MUL_WAIT: on `r_valid`, `acc<=r_out`; then → SQR_REQ, or → DONE if this was the last bit.
  - SQR_REQ: drive `m_a=m_b=sq`; on `m_ready` → SQR_WAIT.
  - SQR_WAIT: on `r_valid`, `sq<=r_out` and advance the bit; then → MUL_REQ if the next bit is 1, else SQR_REQ. A zero last bit → DONE.
  - DONE: `o_valid`=1; on `o_ready` → IDLE.
- `m_modulus = mod_r` at all times.
- Exactly one multiply is outstanding at a time.
- Multiply count with the feature disabled: `popcount(exp) + MOD_WIDTH - 1`.
- `exp = 0` gives `o_out = 1`.

## Timing
- Reset values: `i_ready`=1, `o_valid`=0, `o_out`=0, `m_valid`=0, `m_a`=`m_b`=`m_modulus`=0, `r_ready`=0.
- IDLE→first REQ takes 1 cycle after accept.
- `m_valid` is high in the *_REQ states. It is held, with operands stable, until `m_ready`. It drops the cycle after the handshake.
- `r_ready` is high in the *_WAIT states only.
- A WAIT→next REQ transition takes 1 cycle.
- `o_out` is registered and stable while `o_valid`. `o_valid` and `o_out` are held until `o_ready`.
- `o_valid && o_ready` → IDLE on the next cycle, with `i_ready` high in that cycle.
- `i_valid` outside IDLE is ignored and inputs are not latched.
- `r_valid` outside the WAIT states is ignored.
- Reset mid-job: immediate return to IDLE and all outputs go to their reset values. The multiplier shares `rst`, so no stale product survives.

## Configuration
- `RSA_EXP_EARLY_EXIT_EN` defined:
  - After a bit's multiply (or skip), if the remaining higher exponent bits are all zero, go → DONE without squaring.
  - `exp = 0` goes IDLE→DONE directly, with no multiplier traffic.
- Not defined: all MOD_WIDTH bits are processed.
- `o_out` is identical in both builds; only latency and multiply count differ.

## Structure
- Shared `rsa_pkg`: the `ExpState_t` enum (IDLE, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE) and the default MOD_WIDTH constant.
- One sub-module, `rsa_mul_port`: the request/response shell. It holds `m_valid` and the operands until `m_ready`, asserts `r_ready`, and flags product capture.
- The Montgomery multiplier itself stays external.

## Test plan
All scenarios use MOD_WIDTH=8 and N=13, so R mod 13 = 9.
- Base 2 (`i_base_mont=5`), exp 5 → `o_out=6`. Multiply count is 9 without the macro and 4 with it.
- Base 2, exp 0 → `o_out=1`. Without the macro, 7 squares are issued; with it, 0 multiplies and DONE one cycle after accept.
- Base 3 (`i_base_mont=1`), exp 0xFF → `o_out=1`; 15 multiplies.
- Base 2, exp 0x80 → `o_out = 2^128 mod 13 = 9`, with no multiply issued before the last bit's MUL_REQ.
- Backpressure: `m_ready` low for 3 cycles in every REQ and `o_ready` low for 5 cycles in DONE → operands and `o_out` stay stable; result unchanged.
- Reset asserted during SQR_WAIT → next cycle `i_ready`=1, `m_valid`=0, `o_valid`=0. A fresh job (base 2, exp 5) then returns 6.
